// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - chunk sizing helpers and mode encodings for the pipelined adder
package adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Real bits owned by chunk k; zero when the ceil split leaves trailing chunks empty.
    function automatic int chunk_width(input int width, input int stages, input int k);
        int cw;
        int rem;
        cw  = ceil_div(width, stages);
        rem = width - k * cw;
        if (rem <= 0) return 0;
        if (rem > cw) return cw;
        return rem;
    endfunction

    function automatic int last_chunk_width(input int width, input int stages);
        return chunk_width(width, stages, stages - 1);
    endfunction

    // Position of operand bit width-1 inside a chunk starting at lo, or -1 if elsewhere.
    function automatic int msb_index(input int width, input int lo, input int w);
        if ((width - 1 >= lo) && (width - 1 < lo + w)) return width - 1 - lo;
        return -1;
    endfunction

    localparam int DEFAULT_WIDTH    = 16;
    localparam int DEFAULT_STAGES   = 4;
    localparam int DEFAULT_CW       = ceil_div(DEFAULT_WIDTH, DEFAULT_STAGES);
    localparam int DEFAULT_LAST_CW  = last_chunk_width(DEFAULT_WIDTH, DEFAULT_STAGES);

endpackage

// File: rtl/adder_pipe_stage.sv
// rtl/adder_pipe_stage.sv - one ripple chunk of the pipelined adder plus its register slice
module adder_pipe_stage #(
    parameter int PW  = 16,
    parameter int LO  = 0,
    parameter int W   = 4,
    parameter int MSB = -1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          valid_i,
    input  logic [PW-1:0] a_i,
    input  logic [PW-1:0] b_i,
    input  logic [PW-1:0] sum_i,
    input  logic          carry_i,
    input  logic          ovf_i,
    output logic          valid_o,
    output logic [PW-1:0] a_o,
    output logic [PW-1:0] b_o,
    output logic [PW-1:0] sum_o,
    output logic          carry_o,
    output logic          ovf_o
);

    logic [PW-1:0] sum_d;
    logic          carry_d;
    logic          ovf_d;

    logic          valid_q;
    logic [PW-1:0] a_q;
    logic [PW-1:0] b_q;
    logic [PW-1:0] sum_q;
    logic          carry_q;
    logic          ovf_q;

    generate
        if (W > 0) begin : g_chunk
            logic [W:0]   c;
            logic [W-1:0] s;

            assign c[0] = carry_i;
            for (genvar j = 0; j < W; j++) begin : g_bit
                full_adder u_fa (
                    .a_i (a_i[LO+j]),
                    .b_i (b_i[LO+j]),
                    .c_i (c[j]),
                    .s_o (s[j]),
                    .c_o (c[j+1])
                );
            end

            always_comb begin
                sum_d          = sum_i;
                sum_d[LO +: W] = s;
            end
            assign carry_d = c[W];

            if (MSB >= 0) begin : g_msb
                assign ovf_d = c[MSB] ^ c[MSB+1];
            end else begin : g_no_msb
                assign ovf_d = ovf_i;
            end
        end else begin : g_pass
            // Empty trailing chunk: forward the carry out of the true MSB untouched.
            assign sum_d   = sum_i;
            assign carry_d = carry_i;
            assign ovf_d   = ovf_i;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            a_q     <= a_i;
            b_q     <= b_i;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_carry_adder.sv
// rtl/pipelined_carry_adder.sv - STAGES-deep registered ripple add/sub with valid/ready flow control
module pipelined_carry_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH:0]   o_sum,
    output logic             o_overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = ceil_div(WIDTH, STAGES);
    localparam int PW = STAGES * CW;

    // Index 0 is the input side; index k+1 is the output of stage k.
    logic [PW-1:0] a_p   [STAGES+1];
    logic [PW-1:0] b_p   [STAGES+1];
    logic [PW-1:0] s_p   [STAGES+1];
    logic          c_p   [STAGES+1];
    logic          ovf_p [STAGES+1];
    logic          v_p   [STAGES+1];
    logic          en    [STAGES];

    assign a_p[0]   = PW'(a);
    assign b_p[0]   = PW'((sub == MODE_SUB) ? ~b : b);
    assign s_p[0]   = '0;
    assign c_p[0]   = (sub == MODE_SUB) ? 1'b1 : carry_in;
    assign ovf_p[0] = 1'b0;
    assign v_p[0]   = in_valid;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            localparam int LO  = k * CW;
            localparam int W   = chunk_width(WIDTH, STAGES, k);
            localparam int MSB = msb_index(WIDTH, LO, W);

            if (k == STAGES - 1) begin : g_en_last
                assign en[k] = !v_p[k+1] || out_ready;
            end else begin : g_en_mid
                assign en[k] = !v_p[k+1] || en[k+1];
            end

            adder_pipe_stage #(
                .PW  (PW),
                .LO  (LO),
                .W   (W),
                .MSB (MSB)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .en_i    (en[k]),
                .valid_i (v_p[k]),
                .a_i     (a_p[k]),
                .b_i     (b_p[k]),
                .sum_i   (s_p[k]),
                .carry_i (c_p[k]),
                .ovf_i   (ovf_p[k]),
                .valid_o (v_p[k+1]),
                .a_o     (a_p[k+1]),
                .b_o     (b_p[k+1]),
                .sum_o   (s_p[k+1]),
                .carry_o (c_p[k+1]),
                .ovf_o   (ovf_p[k+1])
            );
        end
    endgenerate

    assign in_ready   = en[0];
    assign out_valid  = v_p[STAGES];
    assign o_sum      = {c_p[STAGES], s_p[STAGES][WIDTH-1:0]};
    assign o_overflow = ovf_p[STAGES];

    logic unused_bits;
    assign unused_bits = ^{a_p[STAGES], b_p[STAGES], s_p[STAGES]};

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// tb/tb_pipelined_carry_adder.sv - directed and scoreboarded checks of pipelined_carry_adder
module tb_pipelined_carry_adder;

    logic        clk;
    logic        rst_n;

    logic [15:0] a16, b16;
    logic        cin16, sub16, in_valid16, in_ready16, o_ovf16, out_valid16, out_ready16;
    logic [16:0] o_sum16;

    logic [9:0]  a10, b10;
    logic        cin10, sub10, in_valid10, in_ready10, o_ovf10, out_valid10, out_ready10;
    logic [10:0] o_sum10;

    pipelined_carry_adder #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .carry_in(cin16), .sub(sub16),
        .in_valid(in_valid16), .in_ready(in_ready16), .o_sum(o_sum16),
        .o_overflow(o_ovf16), .out_valid(out_valid16), .out_ready(out_ready16)
    );

    pipelined_carry_adder #(.WIDTH(10), .STAGES(3)) dut10 (
        .clk(clk), .rst_n(rst_n), .a(a10), .b(b10), .carry_in(cin10), .sub(sub10),
        .in_valid(in_valid10), .in_ready(in_ready10), .o_sum(o_sum10),
        .o_overflow(o_ovf10), .out_valid(out_valid10), .out_ready(out_ready10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [16:0] sum;
        logic        ovf;
    } vec_t;

    logic [17:0] exp_q[$];
    int          n_in, n_out, issued, cyc, first_out, last_out;
    logic        need_new;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else passed++;
    endtask

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] bb;
        logic [16:0] s;
        logic        ovf;
        bb  = sub ? ~b : b;
        s   = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
        ovf = (a[15] == bb[15]) && (s[15] != a[15]);
        return {ovf, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_next(input int limit);
        if (issued < limit) begin
            if (need_new) begin
                a16      = 16'($urandom);
                b16      = 16'($urandom);
                cin16    = 1'($urandom);
                sub16    = 1'($urandom);
                need_new = 1'b0;
            end
            in_valid16 = 1'b1;
        end else begin
            in_valid16 = 1'b0;
        end
    endtask

    task automatic sb_cycle();
        #1;
        if (in_valid16 && in_ready16) begin
            exp_q.push_back(model(a16, b16, cin16, sub16));
            n_in++;
            issued++;
            need_new = 1'b1;
        end
        if (out_valid16 && out_ready16) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL sb_unexpected: got %0h with empty scoreboard", {o_ovf16, o_sum16});
            end else begin
                check("sb_result", {o_ovf16, o_sum16}, exp_q.pop_front());
            end
            if (n_out == 0) first_out = cyc;
            last_out = cyc;
            n_out++;
        end
        tick();
    endtask

    task automatic phase_reset();
        n_in = 0; n_out = 0; issued = 0; need_new = 1'b1;
    endtask

    vec_t vecs[9];
    vec_t v10[2];
    logic [16:0] snap_sum;
    logic        snap_ovf;
    int          guard, stray;

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h1_0000, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h0_8000, 1'b1};
        vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0_FFFE, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 17'h1_7FFF, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 17'h0_5556, 1'b0};
        vecs[5] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 17'h1_0002, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 17'h1_0000, 1'b1};
        vecs[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 17'h1_0000, 1'b0};
        vecs[8] = '{16'h0003, 16'h0001, 1'b1, 1'b1, 17'h1_0002, 1'b0};
        v10[0]  = '{16'h03FF, 16'h03FF, 1'b1, 1'b0, 17'h007FF, 1'b0};
        v10[1]  = '{16'h01FF, 16'h0001, 1'b0, 1'b0, 17'h00200, 1'b1};

        rst_n = 1'b0;
        a16 = '0; b16 = '0; cin16 = 0; sub16 = 0; in_valid16 = 0; out_ready16 = 1;
        a10 = '0; b10 = '0; cin10 = 0; sub10 = 0; in_valid10 = 0; out_ready10 = 1;
        cyc = 0; first_out = 0; last_out = 0;
        phase_reset();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid16, 0);
        check("rst_o_sum", o_sum16, 0);
        check("rst_o_overflow", o_ovf16, 0);
        check("rst_in_ready", in_ready16, 1);
        check("rst_in_ready_w10", in_ready10, 1);

        // Directed vectors, one at a time, with latency checked.
        foreach (vecs[i]) begin
            a16 = vecs[i].a; b16 = vecs[i].b; cin16 = vecs[i].cin; sub16 = vecs[i].sub;
            in_valid16 = 1'b1;
            #1;
            check("vec_in_ready", in_ready16, 1);
            tick();
            in_valid16 = 1'b0;
            tick();
            tick();
            check("vec_early_valid", out_valid16, 0);
            tick();
            check("vec_out_valid", out_valid16, 1);
            check("vec_sum", o_sum16, vecs[i].sum);
            check("vec_ovf", o_ovf16, vecs[i].ovf);
        end
        tick();

        // Irregular 10-bit / 3-stage split.
        foreach (v10[i]) begin
            a10 = v10[i].a[9:0]; b10 = v10[i].b[9:0]; cin10 = v10[i].cin; sub10 = v10[i].sub;
            in_valid10 = 1'b1;
            tick();
            in_valid10 = 1'b0;
            tick();
            check("w10_early_valid", out_valid10, 0);
            tick();
            check("w10_out_valid", out_valid10, 1);
            check("w10_sum", o_sum10, v10[i].sum[10:0]);
            check("w10_ovf", o_ovf10, v10[i].ovf);
        end
        tick();

        // Streaming: 20 back-to-back random operations.
        phase_reset();
        guard = 0;
        while (n_out < 20 && guard < 100) begin
            drive_next(20);
            if (in_valid16) begin
                #1;
                check("stream_in_ready", in_ready16, 1);
                #0;
            end
            sb_cycle();
            guard++;
        end
        in_valid16 = 1'b0;
        check("stream_count", n_out, 20);
        check("stream_one_per_cycle", last_out - first_out, 19);

        // Backpressure: six offered, four fit, outputs hold while stalled.
        phase_reset();
        out_ready16 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_next(6);
            sb_cycle();
        end
        check("bp_accepted", n_in, 4);
        check("bp_in_ready_full", in_ready16, 0);
        check("bp_out_valid", out_valid16, 1);
        snap_sum = o_sum16;
        snap_ovf = o_ovf16;
        for (int i = 0; i < 3; i++) begin
            drive_next(6);
            sb_cycle();
            check("bp_hold_sum", o_sum16, snap_sum);
            check("bp_hold_ovf", o_ovf16, snap_ovf);
        end
        check("bp_still_blocked", n_in, 4);
        out_ready16 = 1'b1;
        #1;
        check("bp_in_ready_comb", in_ready16, 1);
        guard = 0;
        while (n_out < 6 && guard < 50) begin
            drive_next(6);
            sb_cycle();
            guard++;
        end
        in_valid16 = 1'b0;
        check("bp_drained", n_out, 6);
        check("bp_queue_empty", exp_q.size(), 0);

        // Reset while three operations are in flight.
        phase_reset();
        for (int i = 0; i < 3; i++) begin
            drive_next(3);
            sb_cycle();
        end
        in_valid16 = 1'b0;
        check("mid_not_yet_valid", out_valid16, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid16, 0);
        check("mid_rst_in_ready", in_ready16, 1);
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid16) stray++;
        end
        check("mid_no_stale", stray, 0);
        check("mid_in_ready", in_ready16, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
- Parametrised, pipelined successor to the combinational ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES registered ripple chunks, with the carry passed between stages.
- Throughput is one operation per cycle; latency is STAGES cycles.
- Valid/ready handshakes on both sides allow full backpressure. Used in datapaths where a WIDTH-bit ripple chain misses timing.

Parameters:
WIDTH  16  operand width in bits; legal range 2..64
STAGES  4  pipeline stages; legal range 1..WIDTH; chunk width CW = ceil(WIDTH/STAGES), the last chunk takes the remainder

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
a  input  WIDTH  operand A
b  input  WIDTH  operand B
carry_in  input  1  carry into bit 0 for add; ignored when sub=1
sub  input  1  0: a+b+carry_in; 1: a-b, computed as a+~b+1
in_valid  input  1  input operation present
in_ready  output  1  block accepts the operation this cycle
o_sum  output  WIDTH+1  result; bit WIDTH is the raw carry out (for sub, 1 = no borrow)
o_overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB
out_valid  output  1  o_sum and o_overflow are valid
out_ready  input  1  downstream accepts the result

Behaviour:
- Reset: asynchronous assertion while rst_n=0. All stage valid bits, out_valid, o_sum and o_overflow clear to 0. in_ready=1 after reset, because the pipe is empty.
- Transfer rules: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Stage k (0..STAGES-1) holds:
  - valid bit v[k];
  - the carry out of chunk k;
  - result chunks 0..k;
  - the unprocessed operand chunks k+1..STAGES-1.
  - The B operand is stored already inverted when sub=1.
- Stage k computation: chunk k = A_chunk + B_chunk + carry from stage k-1. For stage 0 the carry in is (sub ? 1 : carry_in).
- Enable chain:
  - en[STAGES-1] = !v[STAGES-1] || out_ready
  - en[k] = !v[k] || en[k+1]
  - in_ready = en[0], which is combinational through the chain.
- Register update: when en[k]=1, stage k loads from stage k-1 (stage 0 loads from the inputs), and v[k] takes the upstream valid. When en[k]=0, stage k holds all its contents.
- Latency: an input accepted at edge N presents out_valid at edge N+STAGES-1, provided there is no backpressure.
- Throughput: one result per cycle while out_ready=1. Bubbles travel through the pipe without stalling later valid entries.
- Output hold: outputs are driven directly from the last stage's registers. They hold stable while out_valid && !out_ready.
- Full pipe: with out_ready=0 and all v=1, in_ready=0. When out_ready rises, in_ready rises combinationally in the same cycle. The pipe never drops or duplicates an operation.
- o_overflow: computed in the last stage from the carry into the MSB and the carry out of the MSB. Valid only when out_valid=1.
- Width rules:
  - When the last chunk is narrower than CW, only its real bits participate.
  - o_sum[WIDTH] is the carry out of bit WIDTH-1.
  - STAGES=1 degenerates to a single registered ripple adder with latency 1.
- Reset mid-operation: all in-flight operations are discarded. No partial result appears after reset release.
- In-flight operations are independent: carry_in and sub are captured per operation.

Decomposition:
- Package adder_pkg:
  - function ceil_div(WIDTH, STAGES) for CW;
  - localparam for the last chunk width;
  - localparams for the add/sub mode encodings.
- One natural sub-module: adder_pipe_stage.
  - It is a CW-bit ripple chunk built from the existing full_adder cell, plus its valid/enable register slice.
  - It is instantiated STAGES times in a generate loop, with a width parameter so the last chunk can be narrower.

Test Plan:
- WIDTH=16, STAGES=4, out_ready=1: a=0xFFFF, b=0x0001, carry_in=0, sub=0 → out_valid 4 cycles later, o_sum=0x1_0000, o_overflow=0.
- Signed overflow: a=0x7FFF, b=0x0001, add → o_sum=0x0_8000, o_overflow=1. Then a=0x0005, b=0x0007, sub=1 → o_sum=0x0_FFFE (borrow, bit16=0), o_overflow=0.
- Streaming: 20 back-to-back random operations with out_ready=1 → one result per cycle, in order, matching a reference model; in_ready stays 1 throughout.
- Backpressure:
  - Hold out_ready=0 while sending 6 operations. Exactly 4 are accepted and in_ready=0 afterwards.
  - Outputs stay stable while stalled.
  - Raise out_ready: all 6 results emerge in order, with none lost.
- Irregular split: WIDTH=10, STAGES=3 (chunks 4,4,2). a=0x3FF, b=0x3FF, carry_in=1 → o_sum=0x7FF after 3 cycles.
- Reset mid-flight: 3 operations in flight, pulse rst_n low for 1 cycle → out_valid=0 immediately, no stale result afterwards, in_ready=1.
